priority_encoder_pend: RTL and testbench

- Parametrised, registered successor of the 4:2 combinational priority encoder.
- Latches N single-cycle request pulses into a pending register and presents the index of the highest-priority pending request on a valid/ready output.
- Clears each bit when its index is accepted.
- Sits between interrupt/event sources and a single consumer (sequencer or CPU-side service FSM).

---
 rtl/priority_encoder_pend.sv | 109 ++++++++++
 tb/tb_priority_encoder_pend.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/priority_encoder_pend.sv
// Pending-request priority encoder: latches request pulses and presents the winning index on valid/ready.
// Optional round-robin arbitration when PRIORITY_ENC_RR_EN is defined; fixed highest-index priority otherwise.
module priority_encoder_pend #(
    parameter int unsigned N = 8,
    localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         clr,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    input  logic         out_ready,
    output logic [N-1:0] pending,
    output logic         overflow
);

    logic         acc;
    logic         load;
    logic         ovf_hit;
    logic [N-1:0] acc_mask;
    logic [N-1:0] pending_n;
    logic [W-1:0] enc_idx;
    logic         enc_any;

    // Next pending vector: drop the accepted bit, then OR in new pulses.
    always_comb begin
        acc      = out_valid & out_ready;
        acc_mask = '0;
        for (int unsigned i = 0; i < N; i++) begin
            acc_mask[i] = acc && (out_idx == W'(i));
        end
        pending_n = (pending & ~acc_mask) | req;
        ovf_hit   = |(req & pending & ~acc_mask);
        load      = ~out_valid | acc;
        enc_any   = |pending_n;
    end

`ifdef PRIORITY_ENC_RR_EN
    logic [W-1:0] ptr;
    logic [W-1:0] ptr_n;
    logic [W-1:0] lo_idx;
    logic         lo_any;
    logic [W-1:0] hi_idx;

    // Downward search from ptr-1 with wrap: highest set bit below ptr, else highest set bit overall.
    always_comb begin
        ptr_n  = acc ? out_idx : ptr;
        lo_idx = '0;
        lo_any = 1'b0;
        hi_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (pending_n[i]) begin
                hi_idx = W'(i);
                if (W'(i) < ptr_n) begin
                    lo_idx = W'(i);
                    lo_any = 1'b1;
                end
            end
        end
        enc_idx = lo_any ? lo_idx : hi_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_n;
        end
    end
`else
    // Fixed priority: highest set index wins.
    always_comb begin
        enc_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (pending_n[i]) begin
                enc_idx = W'(i);
            end
        end
    end
`endif

    // Output slot only reloads when empty or being accepted, so a presented index stays put.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            overflow  <= 1'b0;
        end else if (clr) begin
            pending   <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            overflow  <= 1'b0;
        end else begin
            pending <= pending_n;
            if (ovf_hit) begin
                overflow <= 1'b1;
            end
            if (load) begin
                out_valid <= enc_any;
                out_idx   <= enc_idx;
            end
        end
    end

endmodule

// File: tb/tb_priority_encoder_pend.sv
// Directed, table-driven bench for priority_encoder_pend (N=8), plus a hand-written async reset sequence.
module tb_priority_encoder_pend;

    localparam int unsigned N = 8;
    localparam int unsigned W = 3;
    localparam int unsigned NV = 27;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic         clr;
    logic         out_valid;
    logic [W-1:0] out_idx;
    logic         out_ready;
    logic [N-1:0] pending;
    logic         overflow;

    int unsigned n_total;
    int unsigned n_pass;

    typedef struct {
        logic [N-1:0] req;
        logic         clr;
        logic         rdy;
        logic         ev;
        logic [W-1:0] eidx;
        logic [N-1:0] epend;
        logic         eovf;
        logic         cidx;
    } vec_t;

    vec_t vecs [NV];

    priority_encoder_pend #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .clr       (clr),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_ready (out_ready),
        .pending   (pending),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [W-1:0] eidx,
                             input logic [N-1:0] epend, input logic eovf, input logic cidx);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
        if (cidx) check({tag, ".out_idx"}, 32'(out_idx), 32'(eidx));
        check({tag, ".pending"}, 32'(pending), 32'(epend));
        check({tag, ".overflow"}, 32'(overflow), 32'(eovf));
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        req       = '0;
        clr       = 1'b0;
        out_ready = 1'b0;

        // req, clr, rdy | valid, idx, pending, overflow, check_idx
        vecs[0]  = '{8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1};  // idle
        vecs[1]  = '{8'h04, 1'b0, 1'b0, 1'b1, 3'd2, 8'h04, 1'b0, 1'b1};  // single pulse
        vecs[2]  = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd2, 8'h04, 1'b0, 1'b1};  // hold
        vecs[3]  = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1};  // accept -> empty
        vecs[4]  = '{8'h12, 1'b0, 1'b1, 1'b1, 3'd4, 8'h12, 1'b0, 1'b1};  // two bits, ready held
        vecs[5]  = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd1, 8'h02, 1'b0, 1'b1};
        vecs[6]  = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1};
        vecs[7]  = '{8'h01, 1'b0, 1'b0, 1'b1, 3'd0, 8'h01, 1'b0, 1'b1};  // stability
        vecs[8]  = '{8'h80, 1'b0, 1'b0, 1'b1, 3'd0, 8'h81, 1'b0, 1'b1};
        vecs[9]  = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd7, 8'h80, 1'b0, 1'b1};
        vecs[10] = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1};
        vecs[11] = '{8'h02, 1'b0, 1'b0, 1'b1, 3'd1, 8'h02, 1'b0, 1'b1};  // overflow
        vecs[12] = '{8'h02, 1'b0, 1'b0, 1'b1, 3'd1, 8'h02, 1'b1, 1'b1};
        vecs[13] = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd1, 8'h02, 1'b1, 1'b1};  // sticky
        vecs[14] = '{8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0};  // clr beats req
        vecs[15] = '{8'h02, 1'b0, 1'b0, 1'b1, 3'd1, 8'h02, 1'b0, 1'b1};
        vecs[16] = '{8'h02, 1'b0, 1'b1, 1'b1, 3'd1, 8'h02, 1'b0, 1'b1};  // re-req during accept
        vecs[17] = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1};
        vecs[18] = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1};  // ready while idle
        vecs[19] = '{8'hFF, 1'b0, 1'b0, 1'b1, 3'd7, 8'hFF, 1'b0, 1'b1};  // all lines
        vecs[20] = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd6, 8'h7F, 1'b0, 1'b1};
        vecs[21] = '{8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0};  // clr beats accept
        vecs[22] = '{8'h81, 1'b0, 1'b1, 1'b1, 3'd7, 8'h81, 1'b0, 1'b1};  // arbitration order
`ifdef PRIORITY_ENC_RR_EN
        vecs[23] = '{8'h80, 1'b0, 1'b1, 1'b1, 3'd0, 8'h81, 1'b0, 1'b1};
        vecs[24] = '{8'h01, 1'b0, 1'b1, 1'b1, 3'd7, 8'h81, 1'b0, 1'b1};
`else
        vecs[23] = '{8'h80, 1'b0, 1'b1, 1'b1, 3'd7, 8'h81, 1'b0, 1'b1};  // bit 0 starves
        vecs[24] = '{8'h80, 1'b0, 1'b1, 1'b1, 3'd7, 8'h81, 1'b0, 1'b1};
`endif
        vecs[25] = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 8'h01, 1'b0, 1'b1};
        vecs[26] = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1};

        repeat (2) @(posedge clk);
        #1 check_all("reset", 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
        @(negedge clk) rst_n = 1'b1;

        // Async reset mid-stream with pending=A5 and a valid output.
        req = 8'hA5;
        @(posedge clk);
        #1 check_all("pre_rst", 1'b1, 3'd7, 8'hA5, 1'b0, 1'b1);
        @(negedge clk);
        req = 8'hFF;
        #2 rst_n = 1'b0;
        #1 check_all("async_rst", 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
        @(posedge clk);
        #1 check_all("in_rst", 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        req   = '0;
        @(posedge clk);
        #1 check_all("post_rst", 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);

        for (int v = 0; v < int'(NV); v++) begin
            @(negedge clk);
            req       = vecs[v].req;
            clr       = vecs[v].clr;
            out_ready = vecs[v].rdy;
            @(posedge clk);
            #1 check_all($sformatf("vec%0d", v), vecs[v].ev, vecs[v].eidx,
                         vecs[v].epend, vecs[v].eovf, vecs[v].cidx);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
